// File: rtl/tracer_pkg.sv
// rtl/tracer_pkg.sv - shared arbiter state type and uDMA constants for the tracer RX path
package tracer_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  localparam logic [1:0] UDMA_SIZE_16 = 2'b01;
  localparam int TIMEOUT_CYCLES_DEFAULT = 256;

endpackage

// File: rtl/tracer_rr_picker.sv
// rtl/tracer_rr_picker.sv - first set request bit at or after a rotating start index
module tracer_rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] kk;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    kk    = '0;
    for (int off = N - 1; off >= 0; off--) begin
      kk = IDX_W'((int'(ptr_i) + off) % N);
      if (req_i[kk]) begin
        gnt_o     = '0;
        gnt_o[kk] = 1'b1;
        idx_o     = kk;
        any_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tracer_rx_arbiter.sv
// rtl/tracer_rx_arbiter.sv - packet-locked round-robin arbiter feeding the uDMA RX data port
// Define TRACER_RX_ARB_WATCHDOG_EN to reclaim the channel from a source that stalls mid-packet.
module tracer_rx_arbiter
  import tracer_pkg::*;
#(
  parameter int NUM_SRC        = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data_i,
  input  logic [NUM_SRC-1:0]            src_valid_i,
  input  logic [NUM_SRC-1:0]            src_last_i,
  output logic [NUM_SRC-1:0]            src_ready_o,
  output logic [1:0]                    data_rx_datasize_o,
  output logic [DATA_WIDTH-1:0]         data_rx_data_o,
  output logic                          data_rx_valid_o,
  input  logic                          data_rx_ready_i,
  output logic [NUM_SRC-1:0]            grant_o,
  output logic                          busy_o,
  output logic [CNT_WIDTH-1:0]          drop_cnt_o
);

  localparam int IDX_W = $clog2(NUM_SRC);

  arb_state_e            state_q;
  logic [IDX_W-1:0]      rr_q;
  logic [IDX_W-1:0]      gidx_q;
  logic [NUM_SRC-1:0]    grant_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  logic [NUM_SRC-1:0]    pick_gnt;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  g_valid;
  logic                  g_last;
  logic                  out_free;
  logic                  accept;
  logic                  stall_abort;
  logic [IDX_W-1:0]      rr_d;

  tracer_rr_picker #(.N(NUM_SRC), .IDX_W(IDX_W)) u_picker (
    .req_i (src_valid_i),
    .ptr_i (rr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    g_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (grant_q[k]) g_data = src_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign g_valid  = |(src_valid_i & grant_q);
  assign g_last   = |(src_last_i & grant_q);
  assign out_free = !out_valid_q || data_rx_ready_i;
  assign accept   = (state_q == ARB_LOCK) && g_valid && out_free;
  assign rr_d     = (gidx_q == IDX_W'(NUM_SRC - 1)) ? '0 : gidx_q + 1'b1;

  assign src_ready_o        = (state_q == ARB_LOCK && out_free) ? grant_q : '0;
  assign data_rx_datasize_o = UDMA_SIZE_16;
  assign data_rx_data_o     = out_data_q;
  assign data_rx_valid_o    = out_valid_q;
  assign grant_o            = grant_q;
  assign busy_o             = (state_q == ARB_LOCK);

`ifdef TRACER_RX_ARB_WATCHDOG_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [STALL_W-1:0]   stall_q;
  logic [CNT_WIDTH-1:0] drop_cnt_q;

  assign stall_abort = (state_q == ARB_LOCK) && !g_valid &&
                       (stall_q == STALL_W'(TIMEOUT_CYCLES - 1));
  assign drop_cnt_o  = drop_cnt_q;

  // Counter sits at zero while idle, so every new grant starts a fresh window.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (state_q != ARB_LOCK || accept || stall_abort) stall_q <= '0;
      else if (!g_valid)                                stall_q <= stall_q + 1'b1;
      if (stall_abort && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign stall_abort    = 1'b0;
  assign drop_cnt_o     = '0;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ARB_IDLE;
      rr_q        <= '0;
      gidx_q      <= '0;
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      // A held word drains independently of the FSM, even after an abort.
      if (accept) begin
        out_data_q  <= g_data;
        out_valid_q <= 1'b1;
      end else if (data_rx_ready_i) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        ARB_IDLE: begin
          if (en_i && pick_any) begin
            grant_q <= pick_gnt;
            gidx_q  <= pick_idx;
            state_q <= ARB_LOCK;
          end
        end
        ARB_LOCK: begin
          if ((accept && g_last) || stall_abort) begin
            grant_q <= '0;
            rr_q    <= rr_d;
            state_q <= ARB_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tracer_rx_arbiter.sv
// tb/tb_tracer_rx_arbiter.sv - randomized self-checking bench for tracer_rx_arbiter
`timescale 1ns/1ps
module tb_tracer_rx_arbiter;

  localparam int NS = 4;
  localparam int DW = 16;
  localparam int TO = 16;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             en_i;
  logic [NS*DW-1:0] src_data_i;
  logic [NS-1:0]    src_valid_i;
  logic [NS-1:0]    src_last_i;
  logic [NS-1:0]    src_ready_o;
  logic [1:0]       data_rx_datasize_o;
  logic [DW-1:0]    data_rx_data_o;
  logic             data_rx_valid_o;
  logic             data_rx_ready_i;
  logic [NS-1:0]    grant_o;
  logic             busy_o;
  logic [7:0]       drop_cnt_o;

  tracer_rx_arbiter #(
    .NUM_SRC(NS), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
    .src_data_i(src_data_i), .src_valid_i(src_valid_i), .src_last_i(src_last_i),
    .src_ready_o(src_ready_o), .data_rx_datasize_o(data_rx_datasize_o),
    .data_rx_data_o(data_rx_data_o), .data_rx_valid_o(data_rx_valid_o),
    .data_rx_ready_i(data_rx_ready_i), .grant_o(grant_o), .busy_o(busy_o),
    .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-source pending words; the driver presents the front word of each queue.
  logic [DW-1:0] q_data[NS][$];
  bit            q_last[NS][$];
  bit            at_start[NS];
  bit            acc[NS];

  logic [DW-1:0] out_q[$];
  int            out_cyc[$];
  int            gnt_log[$];
  logic [DW-1:0] exp_q[$];
  int            exp_gnt[$];
  int            first_gnt_cyc, stab_err, rdy_err, held_cyc;
  logic [NS-1:0] last_grant;
  int            rdy_pct = 100, bubble_pct = 0, stall_at = -1, stall_len = 0;
  bit            done;
  int            m_rr;

  task automatic do_reset;
    @(negedge clk_i);
    rst_i = 1'b1; en_i = 1'b1; data_rx_ready_i = 1'b1;
    src_valid_i = '0; src_last_i = '0; src_data_i = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    for (int k = 0; k < NS; k++) begin
      q_data[k].delete(); q_last[k].delete(); at_start[k] = 1'b1; acc[k] = 1'b0;
    end
    m_rr = 0;
  endtask

  task automatic clear_capture;
    out_q.delete(); out_cyc.delete(); gnt_log.delete();
    first_gnt_cyc = -1; stab_err = 0; rdy_err = 0; held_cyc = 0; last_grant = '0;
  endtask

  task automatic push_pkt(input int s, input int len, input bit rnd, input logic [DW-1:0] base);
    for (int i = 0; i < len; i++) begin
      q_data[s].push_back(rnd ? DW'($urandom) : DW'(base * (i + 1)));
      q_last[s].push_back(i == len - 1);
    end
  endtask

  // Reference: whole packets leave in round-robin order among sources that still hold packets.
  task automatic model_order;
    logic [DW-1:0] cd[NS][$];
    bit            cl[NS][$];
    int            s;
    bit            lst;
    exp_q.delete(); exp_gnt.delete();
    for (int k = 0; k < NS; k++) begin cd[k] = q_data[k]; cl[k] = q_last[k]; end
    while (1) begin
      s = -1;
      for (int i = 0; i < NS; i++)
        if (s < 0 && cd[(m_rr + i) % NS].size() > 0) s = (m_rr + i) % NS;
      if (s < 0) break;
      exp_gnt.push_back(1 << s);
      do begin
        lst = cl[s].pop_front();
        exp_q.push_back(cd[s].pop_front());
      end while (!lst);
      m_rr = (s + 1) % NS;
    end
  endtask

  function automatic int first_diff();
    int n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (out_q[i] !== exp_q[i]) return i;
    if (out_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic int gnt_diff();
    int n = (gnt_log.size() < exp_gnt.size()) ? gnt_log.size() : exp_gnt.size();
    for (int i = 0; i < n; i++) if (gnt_log[i] != exp_gnt[i]) return i;
    if (gnt_log.size() != exp_gnt.size()) return n;
    return -1;
  endfunction

  // Drive at negedge, sample 2ns later; handshakes seen here complete on the next posedge.
  task automatic run(input int max_cyc);
    bit            hold;
    logic [DW-1:0] hold_data, dummy;
    logic [NS-1:0] vtmp, ltmp;
    logic [NS*DW-1:0] dtmp;
    int            pending;
    hold = 1'b0; hold_data = '0; done = 1'b0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      @(negedge clk_i);
      for (int k = 0; k < NS; k++) begin
        if (acc[k]) begin
          at_start[k] = q_last[k].pop_front();
          dummy = q_data[k].pop_front();
          acc[k] = 1'b0;
        end
      end
      vtmp = '0; ltmp = '0; dtmp = '0;
      for (int k = 0; k < NS; k++) begin
        if (q_data[k].size() > 0 && (at_start[k] || $urandom_range(99) >= bubble_pct)) begin
          vtmp[k] = 1'b1; dtmp[k*DW +: DW] = q_data[k][0]; ltmp[k] = q_last[k][0];
        end else begin
          dtmp[k*DW +: DW] = DW'($urandom); ltmp[k] = 1'($urandom_range(1));
        end
      end
      src_valid_i = vtmp; src_last_i = ltmp; src_data_i = dtmp;
      data_rx_ready_i = (c >= stall_at && c < stall_at + stall_len) ? 1'b0 :
                        1'($urandom_range(99) < rdy_pct);
      #2;
      if (hold && (data_rx_valid_o !== 1'b1 || data_rx_data_o !== hold_data)) stab_err++;
      if (data_rx_valid_o && !data_rx_ready_i && src_ready_o !== '0) rdy_err++;
      hold = data_rx_valid_o && !data_rx_ready_i;
      hold_data = data_rx_data_o;
      if (hold) held_cyc++;
      if (data_rx_valid_o && data_rx_ready_i) begin
        out_q.push_back(data_rx_data_o); out_cyc.push_back(c);
      end
      for (int k = 0; k < NS; k++) acc[k] = src_valid_i[k] && src_ready_o[k];
      if (grant_o !== last_grant && grant_o !== '0) begin
        gnt_log.push_back(int'(grant_o));
        if (first_gnt_cyc < 0) first_gnt_cyc = c;
      end
      last_grant = grant_o;
      pending = 0;
      for (int k = 0; k < NS; k++) pending += q_data[k].size();
      done = (pending == 0) && !data_rx_valid_o && (grant_o == '0);
    end
  endtask

  task automatic test_reset;
    #2;
    n_tests++; if (data_rx_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b need 0", data_rx_valid_o); end
    n_tests++; if (data_rx_data_o !== '0) begin n_fail++; $display("FAIL reset_data: got %h need 0", data_rx_data_o); end
    n_tests++; if (grant_o !== '0) begin n_fail++; $display("FAIL reset_grant: got %b need 0", grant_o); end
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b need 0", busy_o); end
    n_tests++; if (src_ready_o !== '0) begin n_fail++; $display("FAIL reset_ready: got %b need 0", src_ready_o); end
    n_tests++; if (drop_cnt_o !== '0) begin n_fail++; $display("FAIL reset_drop: got %0d need 0", drop_cnt_o); end
    n_tests++; if (data_rx_datasize_o !== 2'b01) begin n_fail++; $display("FAIL datasize: got %b need 01", data_rx_datasize_o); end
  endtask

  task automatic test_single_source;
    int d;
    do_reset; clear_capture;
    push_pkt(1, 3, 1'b0, 16'h1111);
    run(40);
    exp_q = '{16'h1111, 16'h2222, 16'h3333};
    n_tests++; if (first_gnt_cyc != 1) begin n_fail++; $display("FAIL single_latency: grant at cycle %0d need 1", first_gnt_cyc); end
    n_tests++; if (gnt_log.size() < 1 || gnt_log[0] != 2) begin n_fail++; $display("FAIL single_grant: got %0d entries need grant 0010", gnt_log.size()); end
    d = first_diff();
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL single_stream: diff at %0d, got %0d words need 3", d, out_q.size()); end
    n_tests++; if (out_cyc.size() != 3 || out_cyc[2] - out_cyc[0] != 2) begin n_fail++; $display("FAIL single_throughput: %0d words not on consecutive cycles", out_cyc.size()); end
    n_tests++; if (!done || grant_o !== '0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL single_release: done %0d grant %b busy %b need 1/0000/0", done, grant_o, busy_o); end
    // Pointer now sits at 2, so src2 outranks src0.
    clear_capture;
    push_pkt(0, 1, 1'b0, 16'hA0A0);
    push_pkt(2, 1, 1'b0, 16'hC0C0);
    run(40);
    exp_gnt = '{4, 1}; exp_q = '{16'hC0C0, 16'hA0A0};
    d = gnt_diff();
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL rr_pointer_grant: diff at %0d, got %0d grants need 0100,0001", d, gnt_log.size()); end
    d = first_diff();
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL rr_pointer_stream: diff at %0d got %0d words need 2", d, out_q.size()); end
  endtask

  task automatic test_contention;
    int d;
    do_reset; clear_capture;
    for (int k = 0; k < NS; k++) push_pkt(k, 2, 1'b1, '0);
    model_order;
    run(100);
    n_tests++; if (gnt_log.size() != 4 || gnt_log[0] != 1 || gnt_log[1] != 2 || gnt_log[2] != 4 || gnt_log[3] != 8)
      begin n_fail++; $display("FAIL contention_grants: got %0d grants need 0001,0010,0100,1000", gnt_log.size()); end
    d = first_diff();
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL contention_stream: diff at %0d got %0d words need %0d", d, out_q.size(), exp_q.size()); end
  endtask

  task automatic test_backpressure;
    int d;
    do_reset; clear_capture;
    push_pkt(0, 5, 1'b1, '0);
    model_order;
    stall_at = 4; stall_len = 5;
    run(60);
    stall_at = -1; stall_len = 0;
    n_tests++; if (!done) begin n_fail++; $display("FAIL bp_timeout: not drained in 60 cycles"); end
    n_tests++; if (held_cyc != 5) begin n_fail++; $display("FAIL bp_held: held %0d cycles need 5", held_cyc); end
    n_tests++; if (stab_err != 0) begin n_fail++; $display("FAIL bp_stable: %0d unstable held cycles need 0", stab_err); end
    n_tests++; if (rdy_err != 0) begin n_fail++; $display("FAIL bp_ready: %0d cycles ready while held need 0", rdy_err); end
    d = first_diff();
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL bp_stream: diff at %0d got %0d words need 5", d, out_q.size()); end
  endtask

  task automatic test_enable;
    int d;
    do_reset; clear_capture;
    push_pkt(0, 4, 1'b1, '0);
    model_order;
    run(3);
    en_i = 1'b0;
    push_pkt(1, 2, 1'b1, '0);
    push_pkt(3, 2, 1'b1, '0);
    run(20);
    d = first_diff();
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL en_complete: diff at %0d got %0d words need 4", d, out_q.size()); end
    n_tests++; if (gnt_log.size() != 1 || grant_o !== '0) begin n_fail++; $display("FAIL en_blocked: %0d grants, grant %b, need 1 grant then 0000", gnt_log.size(), grant_o); end
    n_tests++; if (q_data[1].size() != 2) begin n_fail++; $display("FAIL en_src1_pending: %0d words left need 2", q_data[1].size()); end
    en_i = 1'b1;
    clear_capture;
    model_order;
    run(60);
    n_tests++; if (!done || gnt_log.size() < 1 || gnt_log[0] != 2) begin n_fail++; $display("FAIL en_resume: done %0d with %0d grants, need src1 first", done, gnt_log.size()); end
    d = first_diff();
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL en_resume_stream: diff at %0d got %0d words need %0d", d, out_q.size(), exp_q.size()); end
  endtask

  task automatic test_watchdog;
    int cnt, exp_cnt, exp_drop;
    bit seen;
    logic [NS-1:0] g;
    do_reset;
    src_data_i = '0;
    src_data_i[2*DW +: DW] = 16'h2A2A;
    src_data_i[3*DW +: DW] = 16'h3B3B;
    src_valid_i = 4'b1100; src_last_i = 4'b1000;
    @(negedge clk_i);
    @(negedge clk_i);
    src_valid_i = 4'b1000;
    cnt = 0; seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #2;
      if (data_rx_valid_o && data_rx_ready_i && data_rx_data_o == 16'h2A2A) seen = 1'b1;
      if (grant_o == 4'b0100) cnt++;
      else break;
      @(negedge clk_i);
    end
`ifdef TRACER_RX_ARB_WATCHDOG_EN
    exp_cnt = TO; exp_drop = 1;
    g = '0;
    for (int c = 0; c < 5 && g == '0; c++) begin @(negedge clk_i); #2; g = grant_o; end
    n_tests++; if (g !== 4'b1000) begin n_fail++; $display("FAIL wd_next_grant: got %b need 1000", g); end
`else
    exp_cnt = 40; exp_drop = 0;
    g = grant_o;
    n_tests++; if (g !== 4'b0100) begin n_fail++; $display("FAIL stall_hold: got %b need 0100", g); end
`endif
    n_tests++; if (cnt != exp_cnt) begin n_fail++; $display("FAIL stall_cycles: grant held %0d cycles need %0d", cnt, exp_cnt); end
    n_tests++; if (drop_cnt_o !== 8'(exp_drop)) begin n_fail++; $display("FAIL drop_cnt: got %0d need %0d", drop_cnt_o, exp_drop); end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL stall_first_word: word 2a2a not delivered"); end
  endtask

  task automatic test_reset_mid_packet;
    do_reset; clear_capture;
    push_pkt(0, 3, 1'b1, '0);
    rdy_pct = 0;
    run(5);
    rdy_pct = 100;
    n_tests++; if (data_rx_valid_o !== 1'b1 || busy_o !== 1'b1) begin n_fail++; $display("FAIL midrst_setup: valid %b busy %b need 1/1", data_rx_valid_o, busy_o); end
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    #2;
    n_tests++; if (data_rx_valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b need 0", data_rx_valid_o); end
    n_tests++; if (grant_o !== '0) begin n_fail++; $display("FAIL midrst_grant: got %b need 0", grant_o); end
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b need 0", busy_o); end
    n_tests++; if (drop_cnt_o !== '0) begin n_fail++; $display("FAIL midrst_drop: got %0d need 0", drop_cnt_o); end
    n_tests++; if (src_ready_o !== '0) begin n_fail++; $display("FAIL midrst_ready: got %b need 0", src_ready_o); end
    rst_i = 1'b0;
    do_reset;
  endtask

  task automatic test_random;
    int d;
    do_reset;
    bubble_pct = 25;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < NS; k++) begin
        int npk = $urandom_range(0, 3);
        for (int p = 0; p < npk; p++) push_pkt(k, $urandom_range(1, 5), 1'b1, '0);
      end
      model_order;
      clear_capture;
      rdy_pct = $urandom_range(30, 100);
      run(2000);
      n_tests++; if (!done) begin n_fail++; $display("FAIL rand%0d_timeout: not drained in 2000 cycles", r); end
      d = first_diff();
      n_tests++; if (d >= 0) begin n_fail++; $display("FAIL rand%0d_stream: diff at %0d got %0d words need %0d", r, d, out_q.size(), exp_q.size()); end
      d = gnt_diff();
      n_tests++; if (d >= 0) begin n_fail++; $display("FAIL rand%0d_grants: diff at %0d got %0d grants need %0d", r, d, gnt_log.size(), exp_gnt.size()); end
      n_tests++; if (stab_err != 0 || rdy_err != 0) begin n_fail++; $display("FAIL rand%0d_hold: unstable %0d ready-while-held %0d need 0/0", r, stab_err, rdy_err); end
    end
    bubble_pct = 0; rdy_pct = 100;
  endtask

  initial begin
    rst_i = 1'b1; en_i = 1'b1; data_rx_ready_i = 1'b1;
    src_valid_i = '0; src_last_i = '0; src_data_i = '0;
    do_reset;
    test_reset;
    test_single_source;
    test_contention;
    test_backpressure;
    test_enable;
    test_watchdog;
    test_reset_mid_packet;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
